// File: rtl/mdu_hilo_if.sv
// Operand, HI/LO write and result bundle between
// the control/regfile side and the multiply/divide unit.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             WeHi;
  logic             WeLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, D, WeHi, WeLo,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, D, WeHi, WeLo,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO.
// Shift-add multiply, restoring divide, sign fixup.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic       Clk,
  input logic       Clr,
  mdu_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] mq, mq_n, bop;
  logic [CW-1:0]    cnt;
  logic             is_div, sa, sb, div0;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH:0]     mul_sum, sh, diff;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_a, neg_b;

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

  assign neg_a = ~bus.Op[0] & bus.A[WIDTH-1];
  assign neg_b = ~bus.Op[0] & bus.B[WIDTH-1];
  assign a_mag = neg_a ? -bus.A : bus.A;
  assign b_mag = neg_b ? -bus.B : bus.B;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_sum = acc + (mq[0] ? {1'b0, bop} : '0);
    sh      = {acc[WIDTH-1:0], mq[WIDTH-1]};
    diff    = sh - {1'b0, bop};
    acc_n   = acc;
    mq_n    = mq;
    unique case (1'b1)
      !is_div: begin
        acc_n = {1'b0, mul_sum[WIDTH:1]};
        mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
      end
      is_div && !diff[WIDTH]: begin
        acc_n = diff;
        mq_n  = {mq[WIDTH-2:0], 1'b1};
      end
      default: begin
        acc_n = sh;
        mq_n  = {mq[WIDTH-2:0], 1'b0};
      end
    endcase
  end

  // Divide by zero leaves |A| as remainder, so the
  // remainder sign fix hands back A unchanged.
  always_comb begin
    prod   = {acc[WIDTH-1:0], mq};
    prod_f = (sa ^ sb) ? -prod : prod;
    quo_f  = (sa ^ sb) ? -mq : mq;
    if (div0) quo_f = '1;
    rem_f  = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      acc    <= '0;
      mq     <= '0;
      bop    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            is_div <= bus.Op[1];
            sa     <= neg_a;
            sb     <= neg_b;
            div0   <= bus.Op[1] && (bus.B == '0);
            mq     <= bus.Op[1] ? a_mag : b_mag;
            bop    <= bus.Op[1] ? b_mag : a_mag;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else begin
            if (bus.WeHi) hi_q <= bus.D;
            if (bus.WeLo) lo_q <= bus.D;
          end
        end
        RUN: begin
          acc <= acc_n;
          mq  <= mq_n;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (is_div) begin
            hi_q <= rem_f;
            lo_q <= quo_f;
          end else begin
            hi_q <= prod_f[2*WIDTH-1:WIDTH];
            lo_q <= prod_f[WIDTH-1:0];
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic results,
// latency, busy/done timing, HI/LO writes, reset.
module tb_mdu_hilo;
  logic Clk = 1'b0;
  logic Clr = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.Start = 1'b0;
    bus.WeHi  = 1'b0;
    bus.WeLo  = 1'b0;
  endtask

  // poke: loop index at which a second Start (and
  // optionally WeHi) is driven while the op runs
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo,
                        input int poke, input logic poke_we);
    int lat, busy_cnt, done_cnt;
    logic hi_stable, busy_at_done;
    logic [31:0] hi0, lo0, hi_r, lo_r;
    @(negedge Clk);
    hi0 = bus.Hi;
    lo0 = bus.Lo;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    bus.WeHi  = poke_we;
    bus.D     = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    idle_in();
    bus.A = 32'h0BAD_0BAD;
    bus.B = 32'h0000_0003;
    chk({tag, " busy@start"}, 64'(bus.Busy), 64'd1);
    lat = 0;
    busy_cnt = 1;
    done_cnt = 0;
    hi_stable = 1'b1;
    busy_at_done = 1'b1;
    hi_r = '0;
    lo_r = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i == poke) begin
        bus.Start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd1;
        bus.WeHi  = poke_we;
      end else begin
        idle_in();
      end
      @(posedge Clk);
      #1;
      if (bus.Done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i;
          busy_at_done = bus.Busy;
          hi_r = bus.Hi;
          lo_r = bus.Lo;
        end
      end else if (lat == 0) begin
        if (bus.Busy) busy_cnt++;
        if (bus.Hi !== hi0 || bus.Lo !== lo0) hi_stable = 1'b0;
      end
    end
    idle_in();
    chk({tag, " latency"}, 64'(lat), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, " busy@done"}, 64'(busy_at_done), 64'd0);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " hilo_stable"}, 64'(hi_stable), 64'd1);
    chk({tag, " hi"}, 64'(hi_r), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo_r), 64'(exp_lo));
  endtask

  initial begin
    int dn;
    idle_in();
    bus.Op = 2'b00;
    bus.A  = '0;
    bus.B  = '0;
    bus.D  = '0;
    Clr    = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst hi", 64'(bus.Hi), 64'd0);
    chk("rst lo", 64'(bus.Lo), 64'd0);
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    Clr = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 0, 1'b0);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,
           32'h0000_1234, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("divu_restart", 2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, 4, 1'b0);

    @(negedge Clk);
    bus.WeHi = 1'b1;
    bus.D    = 32'hAAAA_5555;
    @(posedge Clk);
    #1;
    chk("mthi hi", 64'(bus.Hi), 64'hAAAA_5555);
    chk("mthi lo", 64'(bus.Lo), 64'd14);
    bus.WeHi = 1'b0;
    bus.WeLo = 1'b1;
    bus.D    = 32'h1234_5678;
    @(posedge Clk);
    #1;
    chk("mtlo lo", 64'(bus.Lo), 64'h1234_5678);
    chk("mtlo hi", 64'(bus.Hi), 64'hAAAA_5555);
    bus.WeHi = 1'b1;
    bus.D    = 32'h0F0F_F0F0;
    @(posedge Clk);
    #1;
    chk("mtboth hi", 64'(bus.Hi), 64'h0F0F_F0F0);
    chk("mtboth lo", 64'(bus.Lo), 64'h0F0F_F0F0);
    idle_in();

    run_op("divu_we_run", 2'b11, 32'd9, 32'd4,
           32'd1, 32'd2, 10, 1'b1);

    @(negedge Clk);
    bus.Op    = 2'b00;
    bus.A     = 32'd3;
    bus.B     = 32'd5;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    chk("pre_clr busy", 64'(bus.Busy), 64'd1);
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    chk("clr hi", 64'(bus.Hi), 64'd0);
    chk("clr lo", 64'(bus.Lo), 64'd0);
    chk("clr busy", 64'(bus.Busy), 64'd0);
    chk("clr done", 64'(bus.Done), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) dn++;
    end
    chk("clr no_done", 64'(dn), 64'd0);

    run_op("mult_after_clr", 2'b00, 32'd6, 32'hFFFF_FFF9,
           32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
